// File: rtl/simon_core_n.sv
// Simon sequencer: plays a growing random sequence, checks the echoed keys, and tracks score and high score.
// Outputs are registered from the next state, so they change on the same edge as state; key_valid is taken only in USER_WAIT.
module simon_core_n #(
    parameter int          NUM_CH      = 4,
    parameter int          MAX_LEN     = 32,
    parameter int          SHOW_MS     = 300,
    parameter int          GAP_MS      = 100,
    parameter int          MIN_SHOW_MS = 100,
    parameter int          STEP_MS     = 20,
    parameter int          ECHO_MS     = 300,
    parameter int          TIMEOUT_MS  = 3000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       clk_counter,
    input  logic              btn_start,
    input  logic              mode,
    input  logic              key_valid,
    input  logic [2:0]        key_idx,
    output logic [NUM_CH-1:0] led,
    output logic              tone_on,
    output logic [1:0]        tone_kind,
    output logic [2:0]        tone_ch,
    output logic [3:0]        state,
    output logic [7:0]        score,
    output logic [7:0]        high_score
);

    localparam int LW           = $clog2(MAX_LEN + 1);
    localparam int IW           = $clog2(MAX_LEN);
    localparam int INIT_MS      = 500;
    localparam int LVL_MS       = 500;
    localparam int PASS_TONE_MS = 300;
    localparam int END_TONE_MS  = 1000;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_INIT      = 4'd1,
        S_PLAY      = 4'd2,
        S_GAP       = 4'd3,
        S_WAIT      = 4'd4,
        S_ECHO      = 4'd5,
        S_LVL       = 4'd6,
        S_GAME_OVER = 4'd7,
        S_WIN       = 4'd8
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       presc_q, presc_d;
    logic [11:0]       ms_q, ms_d;
    logic [12:0]       ms_now;
    logic              tick;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [LW-1:0]     len_q, len_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [2:0]        key_q, key_d;
    logic [7:0]        score_q, score_d;
    logic [7:0]        hi_q, hi_d;
    logic [11:0]       show_q, show_d;
    logic              mode_q, mode_d;
    logic [NUM_CH-1:0] led_q, led_d;
    logic              tone_on_q, tone_on_d;
    logic [1:0]        kind_q, kind_d;
    logic [2:0]        ch_q, ch_d;

    logic [2:0]        seq_q [MAX_LEN];
    logic              seq_we;
    logic [IW-1:0]     seq_wa;
    logic [2:0]        new_step;
    logic [2:0]        idle_dark;
    logic              key_ok;
    logic              start;

    function automatic logic after_ms(input logic [12:0] now, input logic [12:0] lim);
        return now >= lim;
    endfunction

    function automatic logic [NUM_CH-1:0] onehot(input logic [2:0] c);
        return {{(NUM_CH-1){1'b0}}, 1'b1} << c;
    endfunction

    assign tick     = (presc_q == clk_counter);
    assign ms_now   = {1'b0, ms_q} + {12'd0, tick};
    assign lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign new_step = 3'(32'(lfsr_q[7:0]) % NUM_CH);
    assign key_ok   = ({1'b0, key_idx} < 4'(NUM_CH));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        key_d   = key_q;
        score_d = score_q;
        show_d  = show_q;
        mode_d  = mode_q;
        seq_we  = 1'b0;
        seq_wa  = '0;
        start   = 1'b0;
        case (state_q)
            S_IDLE: if (btn_start) start = 1'b1;
            S_INIT: begin
                if (after_ms(ms_now, 13'(INIT_MS))) begin
                    state_d = S_PLAY;
                    idx_d   = '0;
                end
            end
            S_PLAY: if (after_ms(ms_now, {1'b0, show_q})) state_d = S_GAP;
            S_GAP: begin
                if (after_ms(ms_now, 13'(GAP_MS))) begin
                    if (LW'(idx_q) + 1'b1 == len_q) begin
                        state_d = S_WAIT;
                        idx_d   = '0;
                    end else begin
                        state_d = S_PLAY;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (key_valid && key_ok) begin
                    key_d   = key_idx;
                    state_d = S_ECHO;
                end else if (after_ms(ms_now, 13'(TIMEOUT_MS))) begin
                    state_d = S_GAME_OVER;
                end
            end
            S_ECHO: begin
                if (after_ms(ms_now, 13'(ECHO_MS))) begin
                    if (key_q != seq_q[idx_q]) begin
                        state_d = S_GAME_OVER;
                    end else if (LW'(idx_q) + 1'b1 != len_q) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_WAIT;
                    end else begin
                        score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                        if (len_q == LW'(MAX_LEN)) begin
                            state_d = S_WIN;
                        end else begin
                            seq_we  = 1'b1;
                            seq_wa  = IW'(len_q);
                            len_d   = len_q + 1'b1;
                            state_d = S_LVL;
                        end
                    end
                end
            end
            S_LVL: begin
                if (after_ms(ms_now, 13'(LVL_MS))) begin
                    state_d = S_PLAY;
                    idx_d   = '0;
                    // Speed-up shortens by one step per level, so no multiply by length is needed.
                    if (mode_q) begin
                        show_d = (show_q >= 12'(MIN_SHOW_MS + STEP_MS)) ? show_q - 12'(STEP_MS)
                                                                       : 12'(MIN_SHOW_MS);
                    end
                end
            end
            S_GAME_OVER, S_WIN: if (btn_start) start = 1'b1;
            default: state_d = S_IDLE;
        endcase
        if (start) begin
            state_d = S_INIT;
            score_d = '0;
            len_d   = LW'(1);
            idx_d   = '0;
            seq_we  = 1'b1;
            seq_wa  = '0;
            show_d  = 12'(SHOW_MS);
            mode_d  = mode;
        end
    end

    always_comb begin
        hi_d = hi_q;
        if ((state_d == S_GAME_OVER || state_d == S_WIN) && state_d != state_q && score_d > hi_q)
            hi_d = score_d;
    end

    // The ms counter and prescaler restart together so every state gets whole milliseconds.
    always_comb begin
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
        ms_d    = (tick && ms_q != 12'hFFF) ? ms_q + 12'd1 : ms_q;
        if (state_d != state_q) begin
            presc_d = '0;
            ms_d    = '0;
        end
    end

    assign idle_dark = 3'(32'(ms_d[9:8]) % NUM_CH);

    always_comb begin
        led_d     = '0;
        tone_on_d = 1'b0;
        kind_d    = 2'd0;
        ch_d      = 3'd0;
        case (state_d)
            S_IDLE: led_d = ~onehot(idle_dark);
            S_PLAY: begin
                ch_d      = seq_q[idx_d];
                led_d     = onehot(ch_d);
                tone_on_d = 1'b1;
            end
            S_ECHO: begin
                ch_d      = key_d;
                led_d     = onehot(ch_d);
                tone_on_d = 1'b1;
            end
            S_LVL: begin
                kind_d    = 2'd1;
                tone_on_d = (ms_d < 12'(PASS_TONE_MS));
            end
            S_GAME_OVER: begin
                kind_d    = 2'd2;
                tone_on_d = (ms_d < 12'(END_TONE_MS));
                led_d     = ms_d[7] ? '1 : '0;
            end
            S_WIN: begin
                kind_d    = 2'd3;
                tone_on_d = (ms_d < 12'(END_TONE_MS));
                led_d     = '1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            ms_q      <= '0;
            lfsr_q    <= LFSR_SEED;
            len_q     <= '0;
            idx_q     <= '0;
            key_q     <= '0;
            score_q   <= '0;
            hi_q      <= '0;
            show_q    <= 12'(SHOW_MS);
            mode_q    <= 1'b0;
            led_q     <= '0;
            tone_on_q <= 1'b0;
            kind_q    <= '0;
            ch_q      <= '0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            ms_q      <= ms_d;
            lfsr_q    <= lfsr_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            key_q     <= key_d;
            score_q   <= score_d;
            hi_q      <= hi_d;
            show_q    <= show_d;
            mode_q    <= mode_d;
            led_q     <= led_d;
            tone_on_q <= tone_on_d;
            kind_q    <= kind_d;
            ch_q      <= ch_d;
        end
    end

    always_ff @(posedge clk) begin
        if (seq_we) seq_q[seq_wa] <= new_step;
    end

    assign led        = led_q;
    assign tone_on    = tone_on_q;
    assign tone_kind  = kind_q;
    assign tone_ch    = ch_q;
    assign state      = state_q;
    assign score      = score_q;
    assign high_score = hi_q;

endmodule

// File: tb/tb_simon_core_n.sv
// Directed bench: a MAX_LEN=2 instance for the classic/win path, a default-length instance for speed-up, loss, timeout and reset.
module tb_simon_core_n;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] clk_counter;
    logic [1:0]  btn_v, mode_v, kv_v, ton_v;
    logic [2:0]  ki_v   [2];
    logic [3:0]  led_v  [2];
    logic [1:0]  kind_v [2];
    logic [2:0]  tch_v  [2];
    logic [3:0]  st_v   [2];
    logic [7:0]  sc_v   [2];
    logic [7:0]  hs_v   [2];

    int          tests = 0;
    int          fails = 0;
    int          sel   = 0;
    logic [2:0]  seq_m [32];

    always #5 clk = ~clk;

    simon_core_n #(.ECHO_MS(20)) u_a (
        .clk(clk), .rst(rst), .clk_counter(clk_counter),
        .btn_start(btn_v[0]), .mode(mode_v[0]), .key_valid(kv_v[0]), .key_idx(ki_v[0]),
        .led(led_v[0]), .tone_on(ton_v[0]), .tone_kind(kind_v[0]), .tone_ch(tch_v[0]),
        .state(st_v[0]), .score(sc_v[0]), .high_score(hs_v[0])
    );

    simon_core_n #(.MAX_LEN(2)) u_b (
        .clk(clk), .rst(rst), .clk_counter(clk_counter),
        .btn_start(btn_v[1]), .mode(mode_v[1]), .key_valid(kv_v[1]), .key_idx(ki_v[1]),
        .led(led_v[1]), .tone_on(ton_v[1]), .tone_kind(kind_v[1]), .tone_ch(tch_v[1]),
        .state(st_v[1]), .score(sc_v[1]), .high_score(hs_v[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [3:0] l);
        idx_of = 9;
        for (int k = 0; k < 4; k++) if (l == (4'd1 << k)) idx_of = k;
    endfunction

    task automatic wait_st(input string tag, input logic [3:0] s, input int budget);
        int c = 0;
        while (st_v[sel] !== s && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(tag, st_v[sel], s);
    endtask

    task automatic dwell(input logic [3:0] s, output int total, output int toned);
        total = 0;
        toned = 0;
        while (st_v[sel] === s && total < 5000) begin
            total++;
            if (ton_v[sel]) toned++;
            @(negedge clk);
        end
    endtask

    task automatic press(input logic [2:0] k);
        kv_v[sel] = 1'b1;
        ki_v[sel] = k;
        @(negedge clk);
        kv_v[sel] = 1'b0;
    endtask

    task automatic start_game(input logic m);
        mode_v[sel] = m;
        btn_v[sel]  = 1'b1;
        @(negedge clk);
        btn_v[sel]  = 1'b0;
    endtask

    // Plays back one level, learning the newest step from the lamps, then echoes it (or fails on purpose).
    task automatic play_level(input int len, input int show, input int echo, input bit wrong);
        int ch, total, toned;
        for (int i = 0; i < len; i++) begin
            wait_st("play_state", 4'd2, 2000);
            ch = idx_of(led_v[sel]);
            if (i < len - 1) chk("replay_step", ch, seq_m[i]);
            else begin
                chk("new_step_range", 32'(ch < 4), 1);
                seq_m[i] = 3'(ch);
            end
            chk("play_tone_ch", tch_v[sel], seq_m[i]);
            dwell(4'd2, total, toned);
            if (i == 0) begin
                chk("play_ms", total, show);
                chk("play_tone_ms", toned, show);
                dwell(4'd3, total, toned);
                chk("gap_ms", total, 100);
            end
        end
        for (int i = 0; i < len; i++) begin
            wait_st("wait_state", 4'd4, 2000);
            chk("wait_led_dark", led_v[sel], 0);
            press(wrong ? (seq_m[i] ^ 3'd1) : seq_m[i]);
            chk("echo_state", st_v[sel], 5);
            chk("echo_led", led_v[sel], 4'd1 << (wrong ? (seq_m[i] ^ 3'd1) : seq_m[i]));
            dwell(4'd5, total, toned);
            if (i == 0) chk("echo_ms", total, echo);
            if (wrong) break;
        end
    endtask

    initial begin
        int total, toned, shw, c;
        rst = 1'b1;
        clk_counter = 16'd0;
        btn_v = '0; mode_v = '0; kv_v = '0;
        ki_v[0] = '0; ki_v[1] = '0;
        repeat (3) @(negedge clk);

        sel = 1;
        chk("rst_state", st_v[1], 0);
        chk("rst_led", led_v[1], 0);
        chk("rst_tone", ton_v[1], 0);
        chk("rst_score", sc_v[1], 0);
        chk("rst_high", hs_v[1], 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Classic game on the two-step instance: pass level 1, then win.
        start_game(1'b0);
        chk("init_state", st_v[1], 1);
        dwell(4'd1, total, toned);
        chk("init_ms", total, 500);
        chk("init_score", sc_v[1], 0);
        play_level(1, 300, 300, 1'b0);
        chk("lvl_state", st_v[1], 6);
        chk("lvl_score", sc_v[1], 1);
        chk("lvl_kind", kind_v[1], 1);
        dwell(4'd6, total, toned);
        chk("lvl_ms", total, 500);
        chk("lvl_tone_ms", toned, 300);
        play_level(2, 300, 300, 1'b0);
        chk("win_state", st_v[1], 8);
        chk("win_score", sc_v[1], 2);
        chk("win_high", hs_v[1], 2);
        chk("win_led", led_v[1], 4'hF);
        chk("win_kind", kind_v[1], 3);
        toned = 0;
        for (int i = 0; i < 1100; i++) begin
            if (ton_v[1]) toned++;
            @(negedge clk);
        end
        chk("win_tone_ms", toned, 1000);
        chk("win_hold", st_v[1], 8);
        start_game(1'b0);
        chk("restart_state", st_v[1], 1);
        chk("restart_score", sc_v[1], 0);
        chk("restart_high", hs_v[1], 2);

        // Speed-up game: show time shrinks 20 ms per level down to the 100 ms floor, then a wrong key.
        sel = 0;
        start_game(1'b1);
        dwell(4'd1, total, toned);
        chk("a_init_ms", total, 500);
        for (int lv = 1; lv <= 12; lv++) begin
            shw = 300 - (lv - 1) * 20;
            if (shw < 100) shw = 100;
            play_level(lv, shw, 20, lv == 12);
            if (lv < 12) begin
                chk("a_lvl_state", st_v[0], 6);
                dwell(4'd6, total, toned);
            end
        end
        chk("go_state", st_v[0], 7);
        chk("go_score", sc_v[0], 11);
        chk("go_high", hs_v[0], 11);
        chk("go_kind", kind_v[0], 2);
        toned = 0;
        for (int i = 0; i < 1100; i++) begin
            if (i == 0)   chk("go_led_0", led_v[0], 4'h0);
            if (i == 127) chk("go_led_127", led_v[0], 4'h0);
            if (i == 128) chk("go_led_128", led_v[0], 4'hF);
            if (i == 256) chk("go_led_256", led_v[0], 4'h0);
            if (ton_v[0]) toned++;
            @(negedge clk);
        end
        chk("go_tone_ms", toned, 1000);
        chk("go_hold", st_v[0], 7);

        // Timeout with an out-of-range key in the middle; it must not count as a press.
        start_game(1'b0);
        chk("t_score", sc_v[0], 0);
        chk("t_high", hs_v[0], 11);
        wait_st("t_wait", 4'd4, 3000);
        c = 0;
        while (st_v[0] === 4'd4 && c < 4000) begin
            if (c == 10) begin
                kv_v[0] = 1'b1;
                ki_v[0] = 3'd5;
            end else kv_v[0] = 1'b0;
            @(negedge clk);
            c++;
        end
        kv_v[0] = 1'b0;
        chk("timeout_ms", c, 3000);
        chk("timeout_state", st_v[0], 7);
        chk("timeout_high", hs_v[0], 11);

        // Four clocks per ms, then an asynchronous reset in the middle of PLAY.
        clk_counter = 16'd3;
        start_game(1'b0);
        dwell(4'd1, total, toned);
        chk("init_ms_div4", total, 2000);
        wait_st("r_play", 4'd2, 100);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst2_state", st_v[0], 0);
        chk("rst2_led", led_v[0], 0);
        chk("rst2_tone", ton_v[0], 0);
        chk("rst2_score", sc_v[0], 0);
        chk("rst2_high", hs_v[0], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
